// File: rtl/rptr_empty_fwft.sv
// Read-side controller for the async-compare FIFO: binary/Gray read pointers,
// two-flop empty flag with async preset, and a one-word FWFT output register.
module rptr_empty_fwft #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             aempty_n,
    output logic [ASIZE-1:0] rptr,
    output logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    output logic             rempty
);

    logic [ASIZE-1:0] rbin;
    logic [ASIZE-1:0] rgray;
    logic [ASIZE-1:0] rbin_next;
    logic [ASIZE-1:0] rgray_next;
    logic             rempty2;
    logic             pop;

    function automatic logic [ASIZE-1:0] bin2gray(input logic [ASIZE-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Comparator may drop aempty_n at any time; empty must assert immediately
    // and only release after two clean read-clock edges.
    always_ff @(posedge rclk or negedge aempty_n) begin
        if (!aempty_n) begin
            {rempty, rempty2} <= 2'b11;
        end else if (rrst) begin
            {rempty, rempty2} <= 2'b11;
        end else begin
            {rempty, rempty2} <= {rempty2, 1'b0};
        end
    end

    assign pop        = ~rempty & (~rvalid | rready);
    assign rbin_next  = rbin + 1'b1;
    assign rgray_next = bin2gray(rbin_next);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin  <= '0;
            rgray <= '0;
        end else if (pop) begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
        end
    end

    // Output register refills on pop even when the held word is consumed in
    // the same cycle, keeping one word per cycle while streaming.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (rvalid & rready) begin
            rvalid <= 1'b0;
        end
    end

    assign raddr = rbin;
    assign rptr  = rgray;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Randomized self-checking bench for rptr_empty_fwft against a pop-count /
// edge-count reference model.
module tb_rptr_empty_fwft;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       aempty_n;
    logic [3:0] rptr;
    logic [3:0] raddr;
    logic [7:0] mem_rdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       rempty;

    logic [7:0] mem [16];
    assign mem_rdata = mem[raddr];

    rptr_empty_fwft #(.ASIZE(4), .DSIZE(8)) dut (
        .rclk(rclk), .rrst(rrst), .aempty_n(aempty_n), .rptr(rptr),
        .raddr(raddr), .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .rempty(rempty)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_cnt = words popped (mod 16), m_hi = rclk edges seen with
    // aempty_n high since it last went low or since reset (saturates at 2).
    logic [3:0] m_cnt;
    int         m_hi;
    logic       m_valid;
    logic [7:0] m_data;

    function automatic logic [3:0] gray(input logic [3:0] c);
        return c ^ (c >> 1);
    endfunction

    function automatic logic m_empty();
        return (m_hi < 2);
    endfunction

    task automatic step();
        logic pop;
        @(posedge rclk);
        pop = !m_empty() && (!m_valid || rready);
        if (rrst) begin
            m_cnt = 0; m_hi = 0; m_valid = 0; m_data = 0;
        end else begin
            if (pop) begin
                m_data  = mem[m_cnt];
                m_valid = 1;
                m_cnt   = m_cnt + 1;
            end else if (m_valid && rready) begin
                m_valid = 0;
            end
            if (aempty_n) m_hi = (m_hi >= 2) ? 2 : m_hi + 1;
            else          m_hi = 0;
        end
        #1;
    endtask

    task automatic drop_aempty();
        aempty_n = 1'b0;
        m_hi     = 0;
    endtask

    task automatic test_reset();
        rrst = 1; aempty_n = 0; rready = 0;
        step(); step();
        if (rempty !== 1'b1 || rvalid !== 1'b0 || rptr !== 4'd0 || raddr !== 4'd0 || rdata !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state rempty=%b rvalid=%b rptr=%h raddr=%h rdata=%h exp 1 0 0 0 0",
                     rempty, rvalid, rptr, raddr, rdata);
        end
        n_checks++;
        rrst = 0; rready = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rempty !== 1'b1 || rvalid !== 1'b0 || rptr !== 4'd0 || raddr !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d rempty=%b rvalid=%b rptr=%h raddr=%h exp 1 0 0 0",
                         i, rempty, rvalid, rptr, raddr);
            end
            n_checks++;
        end
    endtask

    task automatic test_first_word();
        rready = 0; aempty_n = 1;
        step();
        if (rempty !== 1'b1) begin
            n_fail++; $display("FAIL first_edge1_rempty got=%b exp=1", rempty);
        end
        n_checks++;
        step();
        if (rempty !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL first_edge2 rempty=%b rvalid=%b exp 0 0", rempty, rvalid);
        end
        n_checks++;
        step();
        if (rvalid !== 1'b1 || rdata !== mem[0] || raddr !== 4'd1 || rptr !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_word rvalid=%b rdata=%h raddr=%h rptr=%b exp 1 %h 1 0001",
                     rvalid, rdata, raddr, rptr, mem[0]);
        end
        n_checks++;
    endtask

    task automatic test_stream();
        logic [3:0] prev;
        logic       saw_wrap = 0;
        rready = 1;
        for (int i = 0; i < 20; i++) begin
            prev = rptr;
            step();
            if (rvalid !== 1'b1 || rdata !== m_data || raddr !== m_cnt || rptr !== gray(m_cnt)) begin
                n_fail++;
                $display("FAIL stream i=%0d rvalid=%b rdata=%h raddr=%h rptr=%b exp 1 %h %h %b",
                         i, rvalid, rdata, raddr, rptr, m_data, m_cnt, gray(m_cnt));
            end
            n_checks++;
            if ($countones(prev ^ rptr) != 1) begin
                n_fail++; $display("FAIL gray_step i=%0d prev=%b now=%b exp one-bit change", i, prev, rptr);
            end
            n_checks++;
            if (prev == 4'b1000 && rptr == 4'b0000 && raddr == 4'd0) saw_wrap = 1;
        end
        if (saw_wrap !== 1'b1) begin
            n_fail++; $display("FAIL wrap_seen got=%b exp=1", saw_wrap);
        end
        n_checks++;
    endtask

    task automatic test_stall();
        logic [7:0] d0;
        logic [3:0] a0, p0;
        rready = 0;
        step();
        d0 = rdata; a0 = raddr; p0 = rptr;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rvalid !== 1'b1 || rdata !== d0 || raddr !== a0 || rptr !== p0 || rdata !== m_data) begin
                n_fail++;
                $display("FAIL stall i=%0d rvalid=%b rdata=%h raddr=%h rptr=%b exp 1 %h %h %b",
                         i, rvalid, rdata, raddr, rptr, d0, a0, p0);
            end
            n_checks++;
        end
        rready = 1;
        step();
        if (rvalid !== 1'b1 || rdata !== m_data || raddr !== m_cnt || rdata !== mem[a0]) begin
            n_fail++;
            $display("FAIL stall_release rdata=%h raddr=%h exp %h %h", rdata, raddr, mem[a0], m_cnt);
        end
        n_checks++;
    endtask

    task automatic test_async_empty();
        logic [7:0] d0;
        rready = 0;
        step();
        d0 = rdata;
        #2 drop_aempty();
        #1;
        if (rempty !== 1'b1) begin
            n_fail++; $display("FAIL async_set rempty=%b exp=1", rempty);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rempty !== 1'b1 || rvalid !== 1'b1 || rdata !== d0) begin
                n_fail++;
                $display("FAIL async_hold i=%0d rempty=%b rvalid=%b rdata=%h exp 1 1 %h", i, rempty, rvalid, rdata, d0);
            end
            n_checks++;
        end
        rready = 1;
        step();
        if (rvalid !== 1'b0 || rempty !== 1'b1) begin
            n_fail++; $display("FAIL async_drain rvalid=%b rempty=%b exp 0 1", rvalid, rempty);
        end
        n_checks++;
        #2 aempty_n = 1;
        step();
        if (rempty !== 1'b1) begin
            n_fail++; $display("FAIL async_release1 rempty=%b exp=1", rempty);
        end
        n_checks++;
        step();
        if (rempty !== 1'b0) begin
            n_fail++; $display("FAIL async_release2 rempty=%b exp=0", rempty);
        end
        n_checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                if (aempty_n) drop_aempty();
                else aempty_n = 1;
            end
            step();
            if (rempty !== m_empty() || rvalid !== m_valid || raddr !== m_cnt || rptr !== gray(m_cnt)
                || (m_valid && rdata !== m_data)) begin
                n_fail++;
                $display("FAIL random i=%0d rempty=%b rvalid=%b raddr=%h rptr=%b rdata=%h exp %b %b %h %b %h",
                         i, rempty, rvalid, raddr, rptr, rdata, m_empty(), m_valid, m_cnt, gray(m_cnt), m_data);
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid_stream();
        int guard = 0;
        aempty_n = 1; rready = 1;
        while (!(m_valid && m_cnt == 4'd7) && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            n_fail++; $display("FAIL midrst_reach raddr=%h rvalid=%b exp 7 1", raddr, rvalid);
        end
        n_checks++;
        if (raddr !== 4'd7 || rvalid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre raddr=%h rvalid=%b exp 7 1", raddr, rvalid);
        end
        n_checks++;
        rrst = 1;
        step();
        if (rvalid !== 1'b0 || raddr !== 4'd0 || rptr !== 4'd0 || rdata !== 8'd0 || rempty !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst rvalid=%b raddr=%h rptr=%b rdata=%h rempty=%b exp 0 0 0000 00 1",
                     rvalid, raddr, rptr, rdata, rempty);
        end
        n_checks++;
        rrst = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        rrst = 1; aempty_n = 0; rready = 0;
        m_cnt = 0; m_hi = 0; m_valid = 0; m_data = 0;
        test_reset();
        test_first_word();
        test_stream();
        test_stall();
        test_async_empty();
        test_random();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
